wb_retire_unit: RTL

- Multi-lane writeback/retire stage for the dual-issue successor of the scalar CPU pipeline. Sits between MEM and the regfile/CSR file.
- Retires up to LANES instructions of one bundle in program order; lane 0 is the oldest.
- Selects the oldest terminating event (exception, ertn or refetch) and squashes younger lanes.
- Drives regfile writes, the CSR exception interface, debug trace and a retired-instruction counter. It commits either all lanes in one cycle or one lane per cycle.

---
 rtl/wb_retire_unit_pkg.sv | 44 ++++
 rtl/wb_lane_select.sv | 48 ++++
 rtl/wb_retire_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_retire_unit_pkg.sv
// Shared writeback/retire definitions: lane limits, bundle field
// widths, exception codes and the per-lane event encoding.
package wb_retire_unit_pkg;

  localparam int LANES_MIN = 1;
  localparam int LANES_MAX = 4;
  localparam int REG_W     = 5;
  localparam int ECODE_W   = 6;
  localparam int ESUB_W    = 9;
  localparam int DBG_WE_W  = 4;

  localparam logic [ECODE_W-1:0] ECODE_INT = 6'h00;
  localparam logic [ECODE_W-1:0] ECODE_ADE = 6'h08;
  localparam logic [ECODE_W-1:0] ECODE_SYS = 6'h0b;
  localparam logic [ECODE_W-1:0] ECODE_BRK = 6'h0c;
  localparam logic [ECODE_W-1:0] ECODE_INE = 6'h0d;

  localparam logic [ESUB_W-1:0] ESUB_ADEF = 9'h000;
  localparam logic [ESUB_W-1:0] ESUB_ADEM = 9'h001;

  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_EX      = 2'd1,
    EV_ERTN    = 2'd2,
    EV_REFETCH = 2'd3
  } wb_event_e;

  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // ex outranks ertn, ertn outranks refetch
  function automatic wb_event_e lane_event(
    input logic ex,
    input logic ertn,
    input logic refetch
  );
    if (ex)           return EV_EX;
    else if (ertn)    return EV_ERTN;
    else if (refetch) return EV_REFETCH;
    else              return EV_NONE;
  endfunction

endpackage

// File: rtl/wb_lane_select.sv
// Lane priority logic: oldest terminating lane, younger-lane squash
// mask, and the next valid lane at or above the serial pointer.
module wb_lane_select
  import wb_retire_unit_pkg::*;
#(
  parameter int LANES = 2,
  localparam int IW = lane_idx_w(LANES)
) (
  input  logic [LANES-1:0] lane_valid,
  input  logic [LANES-1:0] lane_term,
  input  logic [IW-1:0]    ptr,
  output logic             has_t,
  output logic [IW-1:0]    t,
  output logic [LANES-1:0] squash,
  output logic             has_cur,
  output logic [IW-1:0]    cur,
  output logic [IW-1:0]    last_lane
);

  always_comb begin
    has_t     = 1'b0;
    t         = '0;
    has_cur   = 1'b0;
    cur       = '0;
    last_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_term[i]) begin
        has_t = 1'b1;
        t     = IW'(i);
      end
      if (lane_valid[i] && (IW'(i) >= ptr)) begin
        has_cur = 1'b1;
        cur     = IW'(i);
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (lane_valid[i]) last_lane = IW'(i);
    end
  end

  always_comb begin
    squash = '0;
    for (int i = 0; i < LANES; i++) begin
      squash[i] = has_t && (IW'(i) > t);
    end
  end

endmodule

// File: rtl/wb_retire_unit.sv
// Multi-lane writeback/retire stage: commits a bundle in order,
// reports the oldest terminating event and counts retirements.
module wb_retire_unit
  import wb_retire_unit_pkg::*;
#(
  parameter int LANES = 2,
  parameter int SERIAL_COMMIT = 0,
  parameter int XLEN = 32,
  localparam int P = (SERIAL_COMMIT != 0) ? 1 : LANES
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    ws_allowin,
  input  logic                    ms_to_ws_valid,
  input  logic [LANES-1:0]        ms_lane_valid,
  input  logic [LANES*XLEN-1:0]   ms_pc,
  input  logic [LANES-1:0]        ms_rf_we,
  input  logic [LANES*5-1:0]      ms_rf_waddr,
  input  logic [LANES*XLEN-1:0]   ms_rf_wdata,
  input  logic                    ms_csr_re,
  input  logic [LANES-1:0]        ms_ex,
  input  logic [LANES*6-1:0]      ms_ecode,
  input  logic [LANES*9-1:0]      ms_esubcode,
  input  logic [LANES*XLEN-1:0]   ms_vaddr,
  input  logic [LANES-1:0]        ms_ertn,
  input  logic [LANES-1:0]        ms_refetch,
  output logic                    csr_re,
  input  logic [XLEN-1:0]         csr_rvalue,
  output logic                    wb_ex,
  output logic                    ertn_flush,
  output logic                    wb_refetch_flush,
  output logic [XLEN-1:0]         wb_pc,
  output logic [5:0]              wb_ecode,
  output logic [8:0]              wb_esubcode,
  output logic [XLEN-1:0]         wb_vaddr,
  output logic [P-1:0]            ws_rf_we,
  output logic [P*5-1:0]          ws_rf_waddr,
  output logic [P*XLEN-1:0]       ws_rf_wdata,
  output logic [P*XLEN-1:0]       debug_wb_pc,
  output logic [P*4-1:0]          debug_wb_rf_we,
  output logic [P*5-1:0]          debug_wb_rf_wnum,
  output logic [P*XLEN-1:0]       debug_wb_rf_wdata,
  output logic [63:0]             retired_cnt
);

  localparam int IW = lane_idx_w(LANES);
  localparam bit SER = (SERIAL_COMMIT != 0);

  logic                    ws_valid;
  logic [LANES-1:0]        v_r;
  logic [LANES-1:0]        we_r;
  logic [LANES-1:0]        ex_r;
  logic [LANES-1:0]        ertn_r;
  logic [LANES-1:0]        refetch_r;
  logic [LANES*XLEN-1:0]   pc_r;
  logic [LANES*XLEN-1:0]   wdata_r;
  logic [LANES*XLEN-1:0]   vaddr_r;
  logic [LANES*REG_W-1:0]  waddr_r;
  logic [LANES*ECODE_W-1:0] ecode_r;
  logic [LANES*ESUB_W-1:0] esub_r;
  logic                    csr_re_r;
  logic [IW-1:0]           ptr;

  logic                    has_t;
  logic                    has_cur;
  logic [IW-1:0]           t;
  logic [IW-1:0]           cur;
  logic [IW-1:0]           last_lane;
  logic [LANES-1:0]        squash;
  logic [LANES-1:0]        term;
  logic [LANES-1:0]        commit;
  logic [LANES-1:0]        wr;
  logic [LANES-1:0]        wr_win;
  logic                    active;
  logic                    at_t;
  logic                    last;
  logic                    fire;
  logic                    capture;
  wb_event_e               ev;
  logic [63:0]             cnt_inc;

  assign term = v_r & (ex_r | ertn_r | refetch_r);

  wb_lane_select #(
    .LANES(LANES)
  ) u_sel (
    .lane_valid(v_r),
    .lane_term (term),
    .ptr       (ptr),
    .has_t     (has_t),
    .t         (t),
    .squash    (squash),
    .has_cur   (has_cur),
    .cur       (cur),
    .last_lane (last_lane)
  );

  // an excepting terminator neither writes nor retires
  always_comb begin
    commit = '0;
    wr     = '0;
    for (int i = 0; i < LANES; i++) begin
      commit[i] = v_r[i] & ~squash[i]
                & ~(has_t & ex_r[i] & (t == IW'(i)));
      wr[i] = commit[i] & we_r[i]
            & (waddr_r[i*REG_W +: REG_W] != '0);
    end
    wr_win = wr;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (wr[j] && (waddr_r[j*REG_W +: REG_W]
                      == waddr_r[i*REG_W +: REG_W]))
          wr_win[i] = 1'b0;
      end
    end
  end

  always_comb begin
    ev = EV_NONE;
    if (has_t) ev = lane_event(ex_r[t], ertn_r[t], refetch_r[t]);
    at_t   = has_t & has_cur & (cur == t);
    active = ws_valid & has_cur;
    last   = ~has_cur | at_t | (cur == last_lane);
    fire   = ws_valid & has_t & (SER ? at_t : 1'b1);
  end

  assign wb_ex            = fire & (ev == EV_EX);
  assign ertn_flush       = fire & (ev == EV_ERTN);
  assign wb_refetch_flush = fire & (ev == EV_REFETCH);

  assign ws_allowin = SER ? (~ws_valid | (last & ~fire))
                          : (~ws_valid | ~fire);
  assign capture    = ms_to_ws_valid & ws_allowin;
  assign csr_re     = ws_valid & csr_re_r;

  always_comb begin
    wb_pc       = '0;
    wb_ecode    = '0;
    wb_esubcode = '0;
    wb_vaddr    = '0;
    if (ws_valid && has_t) begin
      wb_pc       = pc_r[int'(t)*XLEN +: XLEN];
      wb_ecode    = ecode_r[int'(t)*ECODE_W +: ECODE_W];
      wb_esubcode = esub_r[int'(t)*ESUB_W +: ESUB_W];
      wb_vaddr    = vaddr_r[int'(t)*XLEN +: XLEN];
    end
  end

  always_comb begin
    cnt_inc = '0;
    if (SER) begin
      if (active && commit[cur]) cnt_inc = 64'd1;
    end else if (ws_valid) begin
      for (int i = 0; i < LANES; i++) begin
        cnt_inc = cnt_inc + 64'(commit[i]);
      end
    end
  end

  // each port p maps to lane p, or to the pointed lane when serial
  always_comb begin
    logic [IW-1:0]   ln;
    logic            pw;
    logic [XLEN-1:0] pd;
    ws_rf_we          = '0;
    ws_rf_waddr       = '0;
    ws_rf_wdata       = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_we    = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    for (int p = 0; p < P; p++) begin
      ln = SER ? cur : IW'(p);
      pw = SER ? (active & wr[cur]) : (ws_valid & wr_win[p]);
      pd = wdata_r[int'(ln)*XLEN +: XLEN];
      if ((ln == '0) && csr_re_r) pd = csr_rvalue;
      ws_rf_we[p]                    = pw;
      debug_wb_rf_we[p*DBG_WE_W +: DBG_WE_W] = {DBG_WE_W{pw}};
      if (ws_valid) begin
        ws_rf_waddr[p*REG_W +: REG_W]      = waddr_r[int'(ln)*REG_W +: REG_W];
        debug_wb_rf_wnum[p*REG_W +: REG_W] = waddr_r[int'(ln)*REG_W +: REG_W];
        ws_rf_wdata[p*XLEN +: XLEN]        = pd;
        debug_wb_rf_wdata[p*XLEN +: XLEN]  = pd;
        debug_wb_pc[p*XLEN +: XLEN]        = pc_r[int'(ln)*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_valid    <= 1'b0;
      v_r         <= '0;
      we_r        <= '0;
      ex_r        <= '0;
      ertn_r      <= '0;
      refetch_r   <= '0;
      pc_r        <= '0;
      wdata_r     <= '0;
      vaddr_r     <= '0;
      waddr_r     <= '0;
      ecode_r     <= '0;
      esub_r      <= '0;
      csr_re_r    <= 1'b0;
      ptr         <= '0;
      retired_cnt <= '0;
    end else begin
      if (ws_allowin)  ws_valid <= ms_to_ws_valid;
      else if (fire)   ws_valid <= 1'b0;
      if (capture) begin
        v_r       <= ms_lane_valid;
        we_r      <= ms_rf_we;
        ex_r      <= ms_ex;
        ertn_r    <= ms_ertn;
        refetch_r <= ms_refetch;
        pc_r      <= ms_pc;
        wdata_r   <= ms_rf_wdata;
        vaddr_r   <= ms_vaddr;
        waddr_r   <= ms_rf_waddr;
        ecode_r   <= ms_ecode;
        esub_r    <= ms_esubcode;
        csr_re_r  <= ms_csr_re;
        ptr       <= '0;
      end else if (SER && active && !last) begin
        ptr <= cur + IW'(1);
      end
      retired_cnt <= retired_cnt + cnt_inc;
    end
  end

endmodule
